mul_hilo_ctrl: RTL and testbench

//  EX-stage multiply controller wrapping the multi-cycle `mul` unit: latches MULT/MULTU/MUL(/MADD/MSUB)

---
 rtl/mul_hilo_ctrl_pkg.sv | 37 +++
 rtl/mul_hilo_ctrl.sv | 137 +++++++++++++
 tb/tb_mul_hilo_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply controller: op codes, FSM states and mul result width.
package mul_hilo_ctrl_pkg;

    localparam int unsigned MUL_RES_W = 66;

    typedef enum logic [2:0] {
        MUL_OP_MULT  = 3'd0,
        MUL_OP_MULTU = 3'd1,
        MUL_OP_MUL   = 3'd2,
        MUL_OP_MADD  = 3'd3,
        MUL_OP_MADDU = 3'd4,
        MUL_OP_MSUB  = 3'd5,
        MUL_OP_MSUBU = 3'd6
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACC   = 3'd3,
        ST_DRAIN = 3'd4
    } mul_state_e;

    function automatic logic op_is_unsigned(input logic [2:0] op);
        return (op == MUL_OP_MULTU) || (op == MUL_OP_MADDU) || (op == MUL_OP_MSUBU);
    endfunction

    function automatic logic op_is_accum(input logic [2:0] op);
        return (op == MUL_OP_MADD) || (op == MUL_OP_MADDU) ||
               (op == MUL_OP_MSUB) || (op == MUL_OP_MSUBU);
    endfunction

    function automatic logic op_is_sub(input logic [2:0] op);
        return (op == MUL_OP_MSUB) || (op == MUL_OP_MSUBU);
    endfunction

endpackage

// File: rtl/mul_hilo_ctrl.sv
// EX-stage multiply controller: issues to the multi-cycle mul unit, stalls until done, owns HI/LO.
// Define MUL_ACCUM_EN to support MADD/MADDU/MSUB/MSUBU through the ACC state.
module mul_hilo_ctrl
    import mul_hilo_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ex_op_valid,
    input  logic [2:0]           ex_op,
    input  logic [31:0]          ex_src1,
    input  logic [31:0]          ex_src2,
    input  logic                 flush,
    input  logic                 hi_we,
    input  logic                 lo_we,
    input  logic [31:0]          hilo_wdata,
    output logic                 mul_valid,
    output logic [31:0]          mul1,
    output logic [31:0]          mul2,
    output logic                 mul_unsigned,
    input  logic [MUL_RES_W-1:0] mul_result,
    input  logic                 mul_done,
    output logic                 stall,
    output logic                 gpr_wvalid,
    output logic [31:0]          gpr_wdata,
    output logic [31:0]          hi,
    output logic [31:0]          lo
);

    mul_state_e  state, state_nxt;
    logic [2:0]  op_q;
    logic        op_ok;
    logic        accept;
    logic        commit_hilo;
    logic [63:0] product;
    logic [1:0]  unused_res_top;

    assign product        = mul_result[63:0];
    assign unused_res_top = mul_result[MUL_RES_W-1:64];

`ifdef MUL_ACCUM_EN
    logic [63:0] acc_prod;
    assign op_ok = (ex_op <= 3'(MUL_OP_MSUBU));
`else
    // Accumulate codes fall through as no-ops when the accumulator is not built.
    assign op_ok = (ex_op == MUL_OP_MULT) || (ex_op == MUL_OP_MULTU) || (ex_op == MUL_OP_MUL);
`endif

    assign accept    = ex_op_valid && !flush && op_ok;
    assign gpr_wdata = gpr_wvalid ? product[31:0] : '0;

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        mul_valid   = 1'b0;
        gpr_wvalid  = 1'b0;
        commit_hilo = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mul_valid = 1'b1;
                stall     = 1'b1;
                state_nxt = flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                stall = 1'b1;
                // A completing op commits even if flush arrives in the same cycle.
                if (mul_done) begin
`ifdef MUL_ACCUM_EN
                    if (op_is_accum(op_q)) begin
                        state_nxt = ST_ACC;
                    end else
`endif
                    begin
                        stall     = 1'b0;
                        state_nxt = ST_IDLE;
                        if (op_q == MUL_OP_MUL) gpr_wvalid  = 1'b1;
                        else                    commit_hilo = 1'b1;
                    end
                end else if (flush) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_ACC: begin
                state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                stall = 1'b1;
                if (mul_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            op_q         <= '0;
            mul1         <= '0;
            mul2         <= '0;
            mul_unsigned <= 1'b0;
            hi           <= '0;
            lo           <= '0;
`ifdef MUL_ACCUM_EN
            acc_prod     <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && accept) begin
                op_q         <= ex_op;
                mul1         <= ex_src1;
                mul2         <= ex_src2;
                mul_unsigned <= op_is_unsigned(ex_op);
            end
            if (commit_hilo) begin
                {hi, lo} <= product;
            end
`ifdef MUL_ACCUM_EN
            if (state == ST_WAIT && mul_done) begin
                acc_prod <= product;
            end
            if (state == ST_ACC) begin
                {hi, lo} <= op_is_sub(op_q) ? ({hi, lo} - acc_prod) : ({hi, lo} + acc_prod);
            end
`endif
            if (state == ST_IDLE && !ex_op_valid) begin
                if (hi_we) hi <= hilo_wdata;
                if (lo_we) lo <= hilo_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl with a fixed-latency behavioural mul unit alongside it.
`timescale 1ns/1ps
module tb_mul_hilo_ctrl;
    import mul_hilo_ctrl_pkg::*;

    localparam int unsigned MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_op_valid;
    logic [2:0]  ex_op;
    logic [31:0] ex_src1, ex_src2;
    logic        flush, hi_we, lo_we;
    logic [31:0] hilo_wdata;
    logic        mul_valid, mul_unsigned, mul_done, stall, gpr_wvalid;
    logic [31:0] mul1, mul2, gpr_wdata, hi, lo;
    logic [65:0] mul_result;

    int n_checks = 0;
    int n_errors = 0;

    mul_hilo_ctrl dut (
        .clk(clk), .resetn(resetn), .ex_op_valid(ex_op_valid), .ex_op(ex_op),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
        .hilo_wdata(hilo_wdata), .mul_valid(mul_valid), .mul1(mul1), .mul2(mul2),
        .mul_unsigned(mul_unsigned), .mul_result(mul_result), .mul_done(mul_done),
        .stall(stall), .gpr_wvalid(gpr_wvalid), .gpr_wdata(gpr_wdata), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Behavioural mul unit: result and done arrive MUL_LAT edges after the valid edge.
    logic [31:0]        m_a, m_b;
    logic               m_u;
    int unsigned        m_cnt;
    logic signed [65:0] m_xa, m_xb, m_prod;
    assign m_xa   = {{34{m_a[31] & ~m_u}}, m_a};
    assign m_xb   = {{34{m_b[31] & ~m_u}}, m_b};
    assign m_prod = m_xa * m_xb;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_a <= '0; m_b <= '0; m_u <= 1'b0; m_cnt <= 0;
            mul_done <= 1'b0; mul_result <= '0;
        end else begin
            mul_done <= 1'b0;
            if (mul_valid) begin
                m_a <= mul1; m_b <= mul2; m_u <= mul_unsigned; m_cnt <= MUL_LAT;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    mul_done   <= 1'b1;
                    mul_result <= m_prod;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one op in EX, holding it while stall is high, and returns what was observed.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int mv, output int gw, output logic [31:0] gdat,
                          output int cyc, output bit to);
        bit fin;
        mv = 0; gw = 0; gdat = '0; cyc = 0; to = 1'b0; fin = 1'b0;
        @(negedge clk);
        ex_op_valid = 1'b1; ex_op = op; ex_src1 = a; ex_src2 = b;
        while (!fin) begin
            #1;
            if (mul_valid)  mv++;
            if (gpr_wvalid) begin gw++; gdat = gpr_wdata; end
            if (!stall) fin = 1'b1;
            else if (cyc >= 40) begin to = 1'b1; fin = 1'b1; end
            cyc++;
            @(negedge clk);
        end
        ex_op_valid = 1'b0;
        #1;
        if (gpr_wvalid) gw++;
    endtask

    int          mv, gw, cyc;
    logic [31:0] gdat;
    bit          to, seen_done;
    logic [31:0] exp_hi, exp_lo;

    initial begin
        resetn = 1'b0; ex_op_valid = 1'b0; ex_op = '0; ex_src1 = '0; ex_src2 = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = '0;
        #12;
        check("rst_ctrl", 64'({stall, mul_valid, gpr_wvalid, mul_unsigned}), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_ops", {mul1, mul2}, 64'd0);
        @(negedge clk); resetn = 1'b1;

        // MULTU 10*20
        run_op(MUL_OP_MULTU, 32'd10, 32'd20, mv, gw, gdat, cyc, to);
        check("multu_to", 64'(to), 64'd0);
        check("multu_hilo", {hi, lo}, 64'h00000000_000000C8);
        check("multu_gpr", 64'(gw), 64'd0);
        check("multu_cyc", 64'(cyc), 64'd6);

        // MULT -888*666 = -591408
        run_op(MUL_OP_MULT, -32'sd888, 32'd666, mv, gw, gdat, cyc, to);
        check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFF6F9D0);
        check("mult_mvalid", 64'(mv), 64'd1);
        check("mult_uns", 64'(mul_unsigned), 64'd0);

`ifdef MUL_ACCUM_EN
        // MADD 1000*1000 on -591408 -> 408592
        run_op(MUL_OP_MADD, 32'd1000, 32'd1000, mv, gw, gdat, cyc, to);
        check("madd_hilo", {hi, lo}, 64'h00000000_00063C10);
        check("madd_cyc", 64'(cyc), 64'd7);
        @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; hilo_wdata = '0;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
        #1 check("mthilo_zero", {hi, lo}, 64'd0);
        run_op(MUL_OP_MSUBU, 32'd1, 32'd1, mv, gw, gdat, cyc, to);
        check("msubu_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
        check("msubu_uns", 64'(mul_unsigned), 64'd1);
        exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFF;
`else
        run_op(MUL_OP_MADD, 32'd1000, 32'd1000, mv, gw, gdat, cyc, to);
        check("madd_noop_mv", 64'(mv), 64'd0);
        check("madd_noop_cyc", 64'(cyc), 64'd1);
        check("madd_noop_hilo", {hi, lo}, 64'hFFFFFFFF_FFF6F9D0);
        exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFF6F9D0;
`endif

        // MUL -777700*3 -> GPR only
        run_op(MUL_OP_MUL, -32'sd777700, 32'd3, mv, gw, gdat, cyc, to);
        check("mul_gw", 64'(gw), 64'd1);
        check("mul_gdat", 64'(gdat), 64'h00000000_FFDC6654);
        check("mul_hilo", {hi, lo}, {exp_hi, exp_lo});

        // MULT 5*5 flushed during WAIT
        @(negedge clk); ex_op_valid = 1'b1; ex_op = MUL_OP_MULT; ex_src1 = 32'd5; ex_src2 = 32'd5;
        @(negedge clk);
        @(negedge clk); ex_op_valid = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        cyc = 0; seen_done = 1'b0;
        #1;
        while (stall && cyc < 40) begin
            if (mul_done) seen_done = 1'b1;
            @(negedge clk); #1;
            cyc++;
        end
        check("flush_done_seen", 64'(seen_done), 64'd1);
        check("flush_drain_cyc", 64'(cyc), 64'd3);
        check("flush_hilo", {hi, lo}, {exp_hi, exp_lo});
        run_op(MUL_OP_MULTU, 32'd10, 32'd20, mv, gw, gdat, cyc, to);
        check("post_flush_hilo", {hi, lo}, 64'h00000000_000000C8);

        // Reset asserted mid-WAIT
        @(negedge clk); ex_op_valid = 1'b1; ex_op = MUL_OP_MULT; ex_src1 = 32'd7; ex_src2 = 32'd9;
        @(negedge clk);
        @(negedge clk); #1;
        resetn = 1'b0; ex_op_valid = 1'b0;
        #1;
        check("midrst_ctrl", 64'({stall, mul_valid, gpr_wvalid, mul_unsigned}), 64'd0);
        check("midrst_ops", {mul1, mul2}, 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_gdat", 64'(gpr_wdata), 64'd0);
        @(negedge clk); resetn = 1'b1;

        // MTHI, then MTHI blocked by a (flushed) op in EX
        @(negedge clk); hi_we = 1'b1; hilo_wdata = 32'h00001234;
        @(negedge clk); hi_we = 1'b0;
        #1 check("mthi_hilo", {hi, lo}, 64'h00001234_00000000);
        @(negedge clk); ex_op_valid = 1'b1; flush = 1'b1; ex_op = MUL_OP_MULT;
        hi_we = 1'b1; lo_we = 1'b1; hilo_wdata = 32'h0000BEEF;
        #1 check("flush_idle_stall", 64'(stall), 64'd0);
        @(negedge clk); ex_op_valid = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        #1;
        check("mthi_blocked", {hi, lo}, 64'h00001234_00000000);
        check("flush_idle_state", 64'({stall, mul_valid}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
